// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 8-bit single-cycle CPU: opcode encodings,
// the instruction length rule used by both the fetch unit and the
// controller, and the fetch FSM state encoding.
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_ADD     = 4'd1;
  localparam logic [3:0] OP_SUB     = 4'd2;
  localparam logic [3:0] OP_NAND    = 4'd3;
  localparam logic [3:0] OP_SHL     = 4'd4;
  localparam logic [3:0] OP_SHR     = 4'd5;
  localparam logic [3:0] OP_OUT     = 4'd6;
  localparam logic [3:0] OP_IN      = 4'd7;
  localparam logic [3:0] OP_MOV     = 4'd8;
  localparam logic [3:0] OP_BR      = 4'd9;
  localparam logic [3:0] OP_BRZN    = 4'd10;
  localparam logic [3:0] OP_BRSUB   = 4'd11;
  localparam logic [3:0] OP_RET     = 4'd12;
  localparam logic [3:0] OP_LOAD    = 4'd13;
  localparam logic [3:0] OP_STORE   = 4'd14;
  localparam logic [3:0] OP_LOADIMM = 4'd15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH1  = 2'd1,
    FETCH2  = 2'd2,
    PRESENT = 2'd3
  } fetch_state_t;

  // Instructions carrying an immediate or branch target occupy two bytes;
  // RETURN sits among them numerically but has no operand byte.
  function automatic logic is_two_byte(input logic [3:0] op);
    case (op)
      OP_BR, OP_BRZN, OP_BRSUB, OP_LOAD, OP_STORE, OP_LOADIMM: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Instruction fetch unit. Reads a byte-wide instruction memory through a
// level req/ack handshake, assembles 1- or 2-byte instructions starting at
// the program counter and hands them to the decoder over valid/ready.
// Branch/return redirects reload the PC and abandon any work in flight.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   mem_req/mem_addr  read request (held until ack) and byte address
//   mem_rdata/mem_ack read data and completion (zero-wait allowed)
//   ins_valid/ready   instruction handshake toward the decoder
//   ins_byte1/2,ins_pc assembled instruction and the address of byte1
//   redirect_valid/pc PC reload request and target
// ---------------------------------------------------------------------------
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [7:0]        ins_byte1,
  output logic [7:0]        ins_byte2,
  output logic [ADDR_W-1:0] ins_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              req_gap;
  logic              ack_ok;

  // req_gap forces one request-free cycle after a redirect abandons a live
  // request, so the memory sees the old request end before the new one.
  assign mem_req   = ((state == FETCH1) || (state == FETCH2)) && !req_gap;
  assign mem_addr  = pc;
  assign ins_valid = (state == PRESENT);
  assign ack_ok    = mem_req && mem_ack;

  // Redirect outranks everything; a handshake in the same cycle still
  // completes because the decoder has already taken the instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ins_byte1 <= 8'h00;
      ins_byte2 <= 8'h00;
      ins_pc    <= RESET_PC;
      req_gap   <= 1'b0;
    end else begin
      req_gap <= 1'b0;
      if (redirect_valid) begin
        pc      <= redirect_pc;
        state   <= FETCH1;
        req_gap <= mem_req;
      end else begin
        case (state)
          IDLE: state <= FETCH1;
          FETCH1: begin
            if (ack_ok) begin
              ins_byte1 <= mem_rdata;
              ins_pc    <= pc;
              pc        <= pc + PC_ONE;
              if (is_two_byte(mem_rdata[7:4])) begin
                state <= FETCH2;
              end else begin
                ins_byte2 <= 8'h00;
                state     <= PRESENT;
              end
            end
          end
          FETCH2: begin
            if (ack_ok) begin
              ins_byte2 <= mem_rdata;
              pc        <= pc + PC_ONE;
              state     <= PRESENT;
            end
          end
          PRESENT: begin
            if (ins_ready) state <= FETCH1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
